// File: rtl/ov7670_source_pkg.sv
// ov7670_source_pkg: shared pattern codes, FSM states and luma constants
// for the OV7670 camera emulator. No ports.
package ov7670_source_pkg;

   typedef enum logic [1:0] {
      PAT_SOLID  = 2'd0,
      PAT_STRIPE = 2'd1,
      PAT_CHECK  = 2'd2,
      PAT_GRAD   = 2'd3
   } pattern_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      BACK   = 3'd2,
      ACTIVE = 3'd3,
      FRONT  = 3'd4
   } state_e;

   localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;
   localparam logic [7:0] Y_HI           = 8'hF0;
   localparam logic [7:0] Y_LO           = 8'h10;

   // Pixel coordinates are carried at a fixed width between top and pattern gen.
   localparam int COORD_W = 16;

endpackage

// File: rtl/ov7670_source_if.sv
// ov7670_source_if: emulated camera bus PCLK, VSYNC, HREF, D[7:0].
// master = emulator side (drives), slave = capture side (samples).
interface ov7670_source_if;
   logic       PCLK;
   logic       VSYNC;
   logic       HREF;
   logic [7:0] D;

   modport master (output PCLK, output VSYNC, output HREF, output D);
   modport slave  (input PCLK, input VSYNC, input HREF, input D);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: combinational luma from x_i, y_i, pat_i, level_i -> luma_o.
// Optional crosshair overlay at the frame centre when OV7670_CROSSHAIR_EN is defined.
module ov7670_pattern_gen
   import ov7670_source_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int STRIPE_LOG = 3
) (
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   input  pattern_e           pat_i,
   input  logic [7:0]         level_i,
   output logic [7:0]         luma_o
);

   logic [7:0] base;

   always_comb begin
      base = level_i;
      unique case (pat_i)
         PAT_SOLID:  base = level_i;
         PAT_STRIPE: base = x_i[STRIPE_LOG] ? Y_HI : Y_LO;
         PAT_CHECK:  base = (x_i[STRIPE_LOG] ^ y_i[STRIPE_LOG]) ? Y_HI : Y_LO;
         PAT_GRAD:   base = x_i[7:0];
      endcase
   end

`ifdef OV7670_CROSSHAIR_EN
   logic hit;
   assign hit    = (x_i == COORD_W'(H_ACTIVE / 2)) ||
                   (y_i == COORD_W'(V_ACTIVE / 2));
   assign luma_o = hit ? 8'hFF : base;
`else
   assign luma_o = base;
   // Coordinate bits beyond the pattern taps only matter for the overlay.
   logic unused_xy;
   assign unused_xy = ^{x_i, y_i, COORD_W'(H_ACTIVE), COORD_W'(V_ACTIVE)};
`endif

endmodule

// File: rtl/ov7670_source.sv
// ov7670_source: OV7670 emulator. In: Clock, ResetN, Enable, PatternSel, Level.
// Out: Cam (PCLK/VSYNC/HREF/D), FrameStart, Busy. Overlay macro: OV7670_CROSSHAIR_EN.
module ov7670_source
   import ov7670_source_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int H_BLANK    = 144,
   parameter int V_SYNC     = 3,
   parameter int V_BACK     = 17,
   parameter int V_ACTIVE   = 480,
   parameter int V_FRONT    = 10,
   parameter int STRIPE_LOG = 3
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  Enable,
   input  logic [1:0]            PatternSel,
   input  logic [7:0]            Level,
   ov7670_source_if.master       Cam,
   output logic                  FrameStart,
   output logic                  Busy
);

   localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int BW      = $clog2(H_TOTAL);
   localparam int LW      = $clog2(V_TOTAL);

   state_e        state_q, state_d;
   logic [BW-1:0] byte_q, byte_d;
   logic [LW-1:0] line_q, line_d;
   logic          pclk_q, pclk_d;
   logic          fs_q, fs_d;
   pattern_e      pat_q, pat_d;
   logic [7:0]    level_q, level_d;
   logic          start;

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state_q <= IDLE;
         byte_q  <= '0;
         line_q  <= '0;
         pclk_q  <= 1'b0;
         fs_q    <= 1'b0;
         pat_q   <= PAT_SOLID;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         line_q  <= line_d;
         pclk_q  <= pclk_d;
         fs_q    <= fs_d;
         pat_q   <= pat_d;
         level_q <= level_d;
      end
   end

   // Counters advance only when PCLK falls, so each byte slot is 2 Clocks.
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      line_d  = line_q;
      pat_d   = pat_q;
      level_d = level_q;
      fs_d    = 1'b0;
      start   = 1'b0;
      pclk_d  = (state_q == IDLE) ? 1'b0 : ~pclk_q;
      if (state_q == IDLE) begin
         start = Enable;
      end else if (pclk_q) begin
         if (byte_q == BW'(H_TOTAL - 1)) begin
            byte_d = '0;
            if (line_q == LW'(V_TOTAL - 1)) begin
               line_d = '0;
               if (Enable) start = 1'b1;
               else        state_d = IDLE;
            end else begin
               line_d = line_q + LW'(1);
               if (line_d == LW'(V_SYNC))
                  state_d = BACK;
               else if (line_d == LW'(V_SYNC + V_BACK))
                  state_d = ACTIVE;
               else if (line_d == LW'(V_SYNC + V_BACK + V_ACTIVE))
                  state_d = FRONT;
            end
         end else begin
            byte_d = byte_q + BW'(1);
         end
      end
      if (start) begin
         state_d = SYNC;
         byte_d  = '0;
         line_d  = '0;
         pat_d   = pattern_e'(PatternSel);
         level_d = Level;
         fs_d    = 1'b1;
      end
   end

   logic [COORD_W-1:0] x, y;
   logic [7:0]         luma;
   logic               href;

   assign x = COORD_W'(byte_q >> 1);
   assign y = COORD_W'(line_q - LW'(V_SYNC + V_BACK));

   ov7670_pattern_gen #(
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .STRIPE_LOG (STRIPE_LOG)
   ) u_pat (
      .x_i     (x),
      .y_i     (y),
      .pat_i   (pat_q),
      .level_i (level_q),
      .luma_o  (luma)
   );

   assign href       = (state_q == ACTIVE) && (byte_q < BW'(2 * H_ACTIVE));
   assign Cam.PCLK   = pclk_q;
   assign Cam.VSYNC  = (state_q == SYNC);
   assign Cam.HREF   = href;
   // Even byte slots carry chroma, odd slots carry luma.
   assign Cam.D      = href ? (byte_q[0] ? luma : CHROMA_NEUTRAL) : 8'h00;
   assign FrameStart = fs_q;
   assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ov7670_source.sv
// tb_ov7670_source: directed bench for ov7670_source on a 4x2 frame
// (24 Clocks per line, 120 Clocks per frame).
module tb_ov7670_source;

   localparam int HA    = 4;
   localparam int VA    = 2;
   localparam int FRAME = 120;

   logic       Clock = 1'b0;
   logic       ResetN = 1'b0;
   logic       Enable = 1'b0;
   logic [1:0] PatternSel = 2'd0;
   logic [7:0] Level = 8'h00;
   logic       FrameStart;
   logic       Busy;

   ov7670_source_if cam ();

   ov7670_source #(
      .H_ACTIVE   (4),
      .H_BLANK    (4),
      .V_SYNC     (1),
      .V_BACK     (1),
      .V_ACTIVE   (2),
      .V_FRONT    (1),
      .STRIPE_LOG (1)
   ) dut (
      .Clock      (Clock),
      .ResetN     (ResetN),
      .Enable     (Enable),
      .PatternSel (PatternSel),
      .Level      (Level),
      .Cam        (cam),
      .FrameStart (FrameStart),
      .Busy       (Busy)
   );

   always #5 Clock = ~Clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int outs();
      return {cam.PCLK, cam.VSYNC, cam.HREF, cam.D, FrameStart, Busy};
   endfunction

   typedef struct {
      logic [1:0]  pat;
      logic [7:0]  lvl;
      logic [63:0] ys;
   } vec_t;

   vec_t vecs[5];

   logic [7:0] bytes[$];
   int vs_cnt, first_href, bad_d, bad_bp;

   task automatic wait_fs(output int n);
      n = 0;
      @(negedge Clock);
      while (FrameStart !== 1'b1 && n < 400) begin
         @(negedge Clock);
         n++;
      end
   endtask

   // Sample one frame starting at the FrameStart cycle; at cycle chg_k
   // apply new inputs to test that mid-frame changes are ignored.
   task automatic rec_frame(input int chg_k, input logic [1:0] npat,
                            input logic [7:0] nlvl, input logic nen);
      bytes.delete();
      vs_cnt     = 0;
      first_href = -1;
      bad_d      = 0;
      bad_bp     = 0;
      for (int k = 0; k < FRAME; k++) begin
         if (k > 0) @(negedge Clock);
         if (cam.VSYNC === 1'b1) vs_cnt++;
         if (cam.HREF === 1'b1 && first_href < 0) first_href = k;
         if (cam.HREF !== 1'b1 && cam.D !== 8'h00) bad_d++;
         if (Busy !== 1'b1 || cam.PCLK !== 1'((k % 2))) bad_bp++;
         if (cam.HREF === 1'b1 && cam.PCLK === 1'b1) bytes.push_back(cam.D);
         if (k == chg_k) begin
            PatternSel = npat;
            Level      = nlvl;
            Enable     = nen;
         end
      end
   endtask

   task automatic check_bytes(input string tag, input logic [63:0] ys);
      int   px, ln, e;
      chk({tag, "_nbytes"}, bytes.size(), 16);
      for (int j = 0; j < 16; j++) begin
         px = (j % 8) / 2;
         ln = j / 8;
         if (j % 2 == 0) begin
            e = 8'h80;
         end else begin
            e = ys[63 - 8 * (4 * ln + px) -: 8];
`ifdef OV7670_CROSSHAIR_EN
            if (px == HA / 2 || ln == VA / 2) e = 8'hFF;
`endif
         end
         if (j < bytes.size())
            chk($sformatf("%s_byte%0d", tag, j), bytes[j], e);
      end
   endtask

   initial begin
      int n;
      vecs[0] = '{2'd0, 8'hA5, {8{8'hA5}}};
      vecs[1] = '{2'd1, 8'h00, {8'h10, 8'h10, 8'hF0, 8'hF0,
                                8'h10, 8'h10, 8'hF0, 8'hF0}};
      vecs[2] = '{2'd2, 8'h00, {8'h10, 8'h10, 8'hF0, 8'hF0,
                                8'h10, 8'h10, 8'hF0, 8'hF0}};
      vecs[3] = '{2'd3, 8'h77, {8'h00, 8'h01, 8'h02, 8'h03,
                                8'h00, 8'h01, 8'h02, 8'h03}};
      vecs[4] = '{2'd0, 8'h3C, {8{8'h3C}}};

      Enable     = 1'b1;
      PatternSel = vecs[0].pat;
      Level      = vecs[0].lvl;
      ResetN     = 1'b0;
      repeat (2) @(negedge Clock);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         chk("reset_hold_outputs", outs(), 0);
      end
      ResetN = 1'b1;

      for (int i = 0; i < 5; i++) begin
         vec_t nx;
         nx = (i < 4) ? vecs[i + 1] : vecs[i];
         wait_fs(n);
         chk($sformatf("f%0d_fs_gap", i), n, 0);
         rec_frame(60, nx.pat, nx.lvl, (i < 4));
         chk($sformatf("f%0d_vsync_clocks", i), vs_cnt, 24);
         chk($sformatf("f%0d_first_href", i), first_href, 48);
         chk($sformatf("f%0d_d_blank", i), bad_d, 0);
         chk($sformatf("f%0d_busy_pclk", i), bad_bp, 0);
         check_bytes($sformatf("f%0d", i), vecs[i].ys);
      end

      @(negedge Clock);
      chk("idle_busy", Busy, 0);
      chk("idle_pclk", cam.PCLK, 0);
      chk("idle_fs", FrameStart, 0);
      chk("idle_vsync", cam.VSYNC, 0);
      repeat (10) @(negedge Clock);
      chk("idle_hold", outs(), 0);

      PatternSel = 2'd3;
      Enable     = 1'b1;
      wait_fs(n);
      chk("restart_fs", n, 0);
      for (int k = 1; k <= 50; k++) @(negedge Clock);
      chk("mid_line_href", cam.HREF, 1);
      ResetN = 1'b0;
      @(negedge Clock);
      chk("mid_reset_outputs", outs(), 0);
      repeat (2) @(negedge Clock);
      chk("mid_reset_hold", outs(), 0);
      ResetN = 1'b1;
      wait_fs(n);
      chk("post_reset_fs", n, 0);
      rec_frame(-1, 2'd3, 8'h00, 1'b1);
      chk("post_reset_vsync", vs_cnt, 24);
      chk("post_reset_busy_pclk", bad_bp, 0);
      check_bytes("post_reset", vecs[3].ys);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ov7670_source.md
Name: ov7670_source

Overview:
- Single-clock OV7670 camera emulator. It drives PCLK, VSYNC, HREF and D[7:0] with the same timing and YUV422 byte order (Cb Y0 Cr Y1) that the capture path expects.
- It replaces the physical sensor in simulation and board bring-up, so the capture, binarization and double-buffer logic can run against known synthetic frames.
- It sits between the system clock domain and the camera-side inputs of the capture block.

Parameters:
- H_ACTIVE, 640, active pixels per line (2 bytes per pixel).
- H_BLANK, 144, byte slots per line with HREF low.
- V_SYNC, 3, lines per frame with VSYNC high.
- V_BACK, 17, lines after VSYNC falls and before the first active line.
- V_ACTIVE, 480, active lines per frame.
- V_FRONT, 10, lines after the last active line.
- STRIPE_LOG, 3, log2 of the stripe and checker cell size in pixels.

Ports:
- Clock  in  1  system clock. PCLK = Clock/2.
- ResetN  in  1  synchronous reset, active-low.
- Enable  in  1  run frames while high.
- PatternSel  in  2  0 solid, 1 vertical stripes, 2 checker, 3 horizontal gradient.
- Level  in  8  Y value used in solid mode.
- PCLK  out  1  emulated pixel clock.
- VSYNC  out  1  frame sync, active-high.
- HREF  out  1  line valid, active-high.
- D  out  8  pixel byte.
- FrameStart  out  1  one-Clock pulse when VSYNC rises.
- Busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (ResetN=0 at a Clock edge):
  - All outputs are 0.
  - State is IDLE.
  - All counters are 0.
  - Reset asserted mid-frame aborts the frame immediately. No partial line is completed.
- PCLK:
  - A register that toggles every Clock while not in IDLE.
  - In IDLE it is held at 0.
- Byte-slot advance:
  - One byte slot spans 2 Clocks.
  - VSYNC, HREF and D update only on the Clock edge where PCLK goes 1->0. They are stable at the following PCLK rise.
- Frame geometry:
  - H_TOTAL = 2*H_ACTIVE + H_BLANK byte slots per line.
  - V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT lines per frame.
  - ByteCnt runs 0..H_TOTAL-1 and wraps to 0. LineCnt increments on each ByteCnt wrap.
  - Counter widths: $clog2 of their totals.
- States:
  - IDLE -> SYNC when Enable=1. On this transition, latch PatternSel and Level and pulse FrameStart.
  - SYNC: VSYNC=1. Go to BACK after V_SYNC lines.
  - BACK: go to ACTIVE after V_BACK lines.
  - ACTIVE: HREF=1 for ByteCnt < 2*H_ACTIVE and 0 otherwise. Go to FRONT after V_ACTIVE lines.
  - FRONT: on completing V_FRONT lines, go to SYNC if Enable=1 (latch pattern again, pulse FrameStart), else to IDLE.
- Enable timing: Enable is sampled only at the frame boundary. Deasserting it mid-frame completes the current frame.
- Busy: 1 in every state except IDLE.
- Pixel data (pixel x = ByteCnt>>1, active line y):
  - Bytes with ByteCnt[1:0] = 0 or 2 carry chroma and are 0x80.
  - Bytes with ByteCnt[1:0] = 1 or 3 carry luma Y.
  - Solid: Y = Level.
  - Stripes: Y = x[STRIPE_LOG] ? 0xF0 : 0x10.
  - Checker: Y = (x[STRIPE_LOG] ^ y[STRIPE_LOG]) ? 0xF0 : 0x10.
  - Gradient: Y = x[7:0], wrapping every 256 pixels.
- D is 0 whenever HREF=0.
- Changes to PatternSel or Level mid-frame have no effect until the next frame.

Optional Feature:
- Macro OV7670_CROSSHAIR_EN.
- When defined: a luma byte with x == H_ACTIVE/2 or y == V_ACTIVE/2 is forced to 0xFF, overriding the selected pattern.
- When undefined: no overlay logic is present and output is the pattern only.

Decomposition:
- Shared header/package holds:
  - Pattern codes PAT_SOLID/PAT_STRIPE/PAT_CHECK/PAT_GRAD.
  - State encodings IDLE/SYNC/BACK/ACTIVE/FRONT.
  - Constants CHROMA_NEUTRAL=0x80, Y_HI=0xF0, Y_LO=0x10.
- One sub-module, ov7670_pattern_gen: combinational Y from x, y and the latched pattern (plus the crosshair overlay). The top level keeps the FSM, counters and PCLK generation.

Test Plan (H_ACTIVE=4, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1, STRIPE_LOG=1; giving H_TOTAL=12 slots = 24 Clocks per line, 5 lines = 120 Clocks per frame):
1. Hold ResetN=0 with Enable=1 -> all outputs stay 0. Release reset -> FrameStart pulses once, VSYNC is high for 24 Clocks, then the first HREF rise follows 24 Clocks later.
2. Solid mode, Level=0xA5 -> each active line carries 8 HREF bytes 80 A5 80 A5 80 A5 80 A5, with D=0 in blanking.
3. Stripes mode -> Y per pixel is 10 10 F0 F0 on both lines. Checker mode -> line 0 is 10 10 F0 F0 and line 1 is also 10 10 F0 F0, because y[1]=0 for y=0..1.
4. Drop Enable mid-ACTIVE -> the frame completes (120 Clocks from FrameStart), then state goes to IDLE with Busy=0 and PCLK=0. Raise Enable again -> a new FrameStart.
5. Change PatternSel from solid to gradient mid-frame -> the current frame stays solid. The next frame gives Y = 00 01 02 03.
6. Connect to the capture block, assert ResetN=0 mid-line, then release -> emulator outputs go to 0 immediately. The capture block returns to its wait-for-VSYNC state and the next full frame is captured with the correct pixel count (8 Y writes).
